event_chunk_feeder: RTL and testbench

// - Upstream feeder for the 64->512 event expand/store stage: pulls one SURF chunk

---
 rtl/event_pkg.sv | 13 +
 rtl/event_chunk_feeder.sv | 162 ++++++++++++++++
 tb/tb_event_chunk_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_pkg.sv
// rtl/event_pkg.sv - shared constants and FSM state type for the event chunk feeder
package event_pkg;

  localparam int CHUNK_LEN_DEFAULT = 384;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/event_chunk_feeder.sv
// rtl/event_chunk_feeder.sv - pulls one fixed-length chunk from the link buffer into the store stage
module event_chunk_feeder
  import event_pkg::*;
#(
  parameter int CHUNK_LEN = CHUNK_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        space_avail_i,
  output logic [63:0] payload_o,
  output logic        payload_valid_o,
  output logic        payload_last_o,
  output logic        err_short_o,
  output logic        err_long_o,
  output logic [15:0] chunk_count_o
);

  localparam int CNT_W = $clog2(CHUNK_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNK_LEN - 1);

  // Chunks must keep 12-bit sample packing aligned across 64-bit words.
  if (CHUNK_LEN <= 0 || (CHUNK_LEN % 6) != 0) begin : g_bad_chunk_len
    $error("CHUNK_LEN must be a nonzero multiple of 6");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_payload;
  logic             r_payload_valid;
  logic             r_payload_last;
  logic             r_err_short;
  logic             r_err_long;
  logic [15:0]      r_chunk_count;

  logic             w_at_end;
  logic             w_tready;
  logic             w_emit;
  logic [63:0]      w_emit_data;
  logic             w_emit_last;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic             w_set_short;
  logic             w_set_long;
  logic             w_done;

  assign w_at_end = (r_cnt == LAST_CNT);

  // Next-state and per-cycle actions; every started chunk emits exactly CHUNK_LEN words.
  always_comb begin
    w_state_next = r_state;
    w_tready     = 1'b0;
    w_emit       = 1'b0;
    w_emit_data  = 64'd0;
    w_emit_last  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_set_short  = 1'b0;
    w_set_long   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        // Room is only checked here: once started, a chunk never stalls downstream.
        if (enable_i && space_avail_i && s_axis_tvalid) begin
          w_state_next = STREAM;
        end
      end
      STREAM: begin
        w_tready = 1'b1;
        if (s_axis_tvalid) begin
          w_emit      = 1'b1;
          w_emit_data = s_axis_tdata;
          w_emit_last = w_at_end;
          if (w_at_end) begin
            w_cnt_clr = 1'b1;
            if (s_axis_tlast) begin
              w_done       = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_set_long   = 1'b1;
              w_state_next = DRAIN;
            end
          end else begin
            w_cnt_inc = 1'b1;
            if (s_axis_tlast) begin
              w_set_short  = 1'b1;
              w_state_next = PAD;
            end
          end
        end
      end
      PAD: begin
        w_emit      = 1'b1;
        w_emit_last = w_at_end;
        if (w_at_end) begin
          w_cnt_clr    = 1'b1;
          w_done       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      DRAIN: begin
        // Overrun beats are swallowed up to and including the source's own tlast.
        w_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Word counter, registered output word, sticky error flags and completed-chunk count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt           <= '0;
      r_payload       <= 64'd0;
      r_payload_valid <= 1'b0;
      r_payload_last  <= 1'b0;
      r_err_short     <= 1'b0;
      r_err_long      <= 1'b0;
      r_chunk_count   <= 16'd0;
    end else begin
      r_payload       <= w_emit_data;
      r_payload_valid <= w_emit;
      r_payload_last  <= w_emit_last;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_set_short) r_err_short <= 1'b1;
      if (w_set_long)  r_err_long  <= 1'b1;
      if (w_done)      r_chunk_count <= r_chunk_count + 16'd1;
    end
  end

  assign s_axis_tready   = w_tready;
  assign payload_o       = r_payload;
  assign payload_valid_o = r_payload_valid;
  assign payload_last_o  = r_payload_last;
  assign err_short_o     = r_err_short;
  assign err_long_o      = r_err_long;
  assign chunk_count_o   = r_chunk_count;

endmodule

// File: tb/tb_event_chunk_feeder.sv
// tb/tb_event_chunk_feeder.sv - self-checking bench for event_chunk_feeder with a chunk-level reference model
module tb_event_chunk_feeder;

  localparam int L = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        space_avail_i;
  logic [63:0] payload_o;
  logic        payload_valid_o;
  logic        payload_last_o;
  logic        err_short_o;
  logic        err_long_o;
  logic [15:0] chunk_count_o;

  always #5 clk = ~clk;

  event_chunk_feeder #(.CHUNK_LEN(L)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable_i),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .space_avail_i   (space_avail_i),
    .payload_o       (payload_o),
    .payload_valid_o (payload_valid_o),
    .payload_last_o  (payload_last_o),
    .err_short_o     (err_short_o),
    .err_long_o      (err_long_o),
    .chunk_count_o   (chunk_count_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic [64:0] exp_q[$];   // {last, data} words the store stage must see, in order
  logic [64:0] cap_q[$];   // {last, data} words actually seen
  logic [63:0] beats[$];   // source beats of the chunk being driven
  int          m_count = 0;
  bit          m_short = 0;
  bit          m_long  = 0;
  bit          rst_seen = 0;
  bit          ok;
  bit          space_rand_on = 0;
  logic [64:0] e_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Chunk-level model: a started chunk always yields L words, source data then zeros, last on word L-1.
  task automatic model_push(input int n, input bit full);
    for (int k = 0; k < L; k++) begin
      exp_q.push_back({(k == L - 1), (k < n) ? beats[k] : 64'd0});
    end
    if (full) begin
      m_count = (m_count + 1) & 16'hFFFF;
      if (n < L) m_short = 1;
      if (n > L) m_long  = 1;
    end
  endtask

  function automatic int count_last();
    int nl = 0;
    foreach (cap_q[k]) nl += int'(cap_q[k][64]);
    return nl;
  endfunction

  always @(posedge clk) rst_seen <= !rst_n;

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("rst_valid", payload_valid_o, 0);
      chk("rst_payload", payload_o, 0);
      chk("rst_last", payload_last_o, 0);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_err_short", err_short_o, 0);
      chk("rst_err_long", err_long_o, 0);
      chk("rst_count", chunk_count_o, 0);
      exp_q.delete();
      m_count = 0;
      m_short = 0;
      m_long  = 0;
    end else if (payload_valid_o) begin
      cap_q.push_back({payload_last_o, payload_o});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected no word", payload_o);
      end else begin
        e_word = exp_q.pop_front();
        chk("payload", payload_o, e_word[63:0]);
        chk("payload_last", payload_last_o, e_word[64]);
      end
    end else begin
      chk("idle_payload_zero", payload_o, 0);
      chk("idle_last_zero", payload_last_o, 0);
    end
  end

  task automatic send_chunk(input int n, input int gap, input int abort_after, input bit seq,
                            input int budget, output bit done_ok);
    int  i = 0;
    int  waitc = 0;
    bit  hs;
    beats.delete();
    for (int k = 0; k < n; k++) beats.push_back(seq ? 64'(k + 1) : {$urandom, $urandom});
    done_ok = 1;
    while (i < n) begin
      if (abort_after >= 0 && i == abort_after) break;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beats[i];
      s_axis_tlast  = (i == n - 1);
      @(negedge clk);
      hs = s_axis_tready;
      if (hs && i == 0) model_push(n, abort_after < 0);
      @(posedge clk);
      #1;
      if (hs) begin
        i++;
        waitc = 0;
        if (gap > 0 && i < n) begin
          s_axis_tvalid = 1'b0;
          s_axis_tlast  = 1'b0;
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
        end
      end else begin
        waitc++;
        if (waitc >= budget) begin
          done_ok = 0;
          break;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 64'd0;
  endtask

  task automatic quiesce(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_count"}, chunk_count_o, m_count);
    chk({tag, "_err_short"}, err_short_o, m_short);
    chk({tag, "_err_long"}, err_long_o, m_long);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    enable_i      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 64'd0;
    s_axis_tlast  = 1'b0;
    space_avail_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    enable_i      = 1'b1;
    space_avail_i = 1'b1;
    chk("post_rst_tready", s_axis_tready, 0);
    chk("post_rst_count", chunk_count_o, 0);

    // Nominal chunk 1..12.
    cap_q.delete();
    send_chunk(12, 0, -1, 1, 200, ok);
    chk("nom_ok", ok, 1);
    quiesce("nom");
    chk("nom_words", cap_q.size(), 12);
    chk("nom_w0", cap_q[0][63:0], 64'd1);
    chk("nom_w11", cap_q[11][63:0], 64'd12);
    chk("nom_last11", cap_q[11][64], 1);
    chk("nom_nlast", count_last(), 1);
    chk("nom_count_lit", chunk_count_o, 16'd1);
    chk("nom_errs_lit", {err_short_o, err_long_o}, 0);

    // Short chunk: 5 beats, 7 zero pads, no ready while padding.
    cap_q.delete();
    send_chunk(5, 0, -1, 1, 200, ok);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("pad_tready", s_axis_tready, 0);
    end
    quiesce("short");
    chk("short_words", cap_q.size(), 12);
    chk("short_w4", cap_q[4][63:0], 64'd5);
    chk("short_w4_nolast", cap_q[4][64], 0);
    chk("short_w5", cap_q[5][63:0], 64'd0);
    chk("short_w11", cap_q[11][63:0], 64'd0);
    chk("short_last11", cap_q[11][64], 1);
    chk("short_flag_lit", err_short_o, 1);
    chk("short_count_lit", chunk_count_o, 16'd2);

    // Long chunk: 15 beats, 3 dropped.
    cap_q.delete();
    send_chunk(15, 0, -1, 1, 200, ok);
    quiesce("long");
    chk("long_words", cap_q.size(), 12);
    chk("long_w11", cap_q[11][63:0], 64'd12);
    chk("long_last11", cap_q[11][64], 1);
    chk("long_flag_lit", err_long_o, 1);
    chk("long_count_lit", chunk_count_o, 16'd3);

    // Space gate: nothing starts while the store stage is full; later drops have no effect.
    cap_q.delete();
    space_avail_i = 1'b0;
    fork
      send_chunk(12, 0, -1, 1, 500, ok);
      begin
        repeat (20) begin
          @(negedge clk);
          chk("gate_tready", s_axis_tready, 0);
          chk("gate_valid", payload_valid_o, 0);
        end
        @(posedge clk);
        #1;
        space_avail_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("gate_start", s_axis_tready, 1);
        repeat (3) @(posedge clk);
        #1;
        space_avail_i = 1'b0;
      end
    join
    chk("gate_ok", ok, 1);
    quiesce("gate");
    chk("gate_words", cap_q.size(), 12);
    space_avail_i = 1'b1;

    // Reset after beat 6 abandons the chunk; the next chunk is whole.
    send_chunk(12, 0, 6, 1, 200, ok);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rstmid_count_lit", chunk_count_o, 16'd0);
    cap_q.delete();
    send_chunk(12, 0, -1, 1, 200, ok);
    quiesce("after_rst");
    chk("after_rst_words", cap_q.size(), 12);
    chk("after_rst_w11", cap_q[11][63:0], 64'd12);
    chk("after_rst_nlast", count_last(), 1);
    chk("after_rst_count_lit", chunk_count_o, 16'd1);

    // Gapped tvalid with enable dropped mid-chunk; no restart afterwards.
    cap_q.delete();
    fork
      send_chunk(12, 2, -1, 1, 500, ok);
      begin
        repeat (10) @(posedge clk);
        #1;
        enable_i = 1'b0;
      end
    join
    chk("gap_ok", ok, 1);
    quiesce("gap");
    chk("gap_words", cap_q.size(), 12);
    chk("gap_w11", cap_q[11][63:0], 64'd12);
    send_chunk(12, 0, -1, 1, 15, ok);
    chk("disabled_no_start", ok, 0);
    chk("disabled_no_words", cap_q.size(), 12);
    enable_i = 1'b1;

    // Randomized chunk lengths, gaps and store-stage room.
    space_rand_on = 1;
    fork
      while (space_rand_on) begin
        @(posedge clk);
        #1;
        space_avail_i = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int c = 0; c < 40; c++) begin
      int n;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       n = L;
        1:       n = $urandom_range(1, L - 1);
        2:       n = $urandom_range(L + 1, L + 8);
        default: n = $urandom_range(1, L + 8);
      endcase
      send_chunk(n, $urandom_range(0, 2), -1, 0, 2000, ok);
      chk("rand_ok", ok, 1);
    end
    space_rand_on = 0;
    @(posedge clk);
    #2;
    space_avail_i = 1'b1;
    quiesce("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
